// File: rtl/flow_pkg.sv
// Shared types for the flow solver scheduler.
// Holds data widths, the tensor-sum bundle and the scheduler state encoding.
package flow_pkg;

    localparam int ACCUM_WIDTH = 32;
    localparam int FLOW_WIDTH  = 16;
    localparam int FRAC_BITS   = 7;

    // First member is the MSB: ixix occupies the lowest ACCUM_WIDTH bits.
    typedef struct packed {
        logic signed [ACCUM_WIDTH-1:0] iyit;
        logic signed [ACCUM_WIDTH-1:0] ixit;
        logic signed [ACCUM_WIDTH-1:0] ixiy;
        logic signed [ACCUM_WIDTH-1:0] iyiy;
        logic signed [ACCUM_WIDTH-1:0] ixix;
    } tensor_sums_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESULT
    } sched_state_t;

endpackage

// File: rtl/flow_solver_sched_rr_arbiter.sv
// Combinational round-robin arbiter (module rr_arbiter).
// Ports: i_req request vector, i_ptr search start,
//        o_grant one-hot grant, o_idx grant index, o_any some request set.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_k;
    logic          w_found;

    // Visit lanes ptr, ptr+1, ... (mod N); first requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = IW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/flow_solver_sched.sv
// Shares one multi-cycle flow solver among NUM_REQ accumulator lanes.
// Ports: req_* lane handshake + sums, solver_* launch/result interface,
//        out_* tagged flow result handshake, clk / rst (sync, active-high).
// Optional watchdog: define FLOW_SOLVER_SCHED_TIMEOUT_EN.
module flow_solver_sched
    import flow_pkg::sched_state_t, flow_pkg::IDLE, flow_pkg::LAUNCH,
           flow_pkg::WAIT, flow_pkg::RESULT;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int ACCUM_WIDTH    = 32,
    parameter  int FLOW_WIDTH     = 16,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IDW            = $clog2(NUM_REQ),
    localparam int SW             = 5 * ACCUM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SW-1:0]   req_sums,
    output logic                    solver_start,
    output logic [SW-1:0]           solver_sums,
    input  logic                    solver_done,
    input  logic [FLOW_WIDTH-1:0]   solver_u,
    input  logic [FLOW_WIDTH-1:0]   solver_v,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FLOW_WIDTH-1:0]   out_u,
    output logic [FLOW_WIDTH-1:0]   out_v,
    output logic [IDW-1:0]          out_id,
    output logic                    out_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("flow_solver_sched: parameter out of range");
    end

    sched_state_t          r_state;
    sched_state_t          w_next;
    logic [IDW-1:0]        r_ptr;
    logic [IDW-1:0]        r_id;
    logic [IDW-1:0]        r_out_id;
    logic [SW-1:0]         r_sums;
    logic [FLOW_WIDTH-1:0] r_u;
    logic [FLOW_WIDTH-1:0] r_v;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDW-1:0]        w_gidx;
    logic                  w_any;
    logic                  w_take;
    logic                  w_expire;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_take    = (r_state == IDLE) && w_any;
    assign req_ready = w_take ? w_grant : '0;

`ifdef FLOW_SOLVER_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_to;

    // Counter equals the number of WAIT cycles already spent.
    assign w_expire = (r_state == WAIT) && !solver_done
                      && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            r_cnt <= (r_state == WAIT) ? r_cnt + CW'(1) : '0;
            if (r_state == WAIT && (solver_done || w_expire)) begin
                r_to <= w_expire;
            end
        end
    end

    assign out_timeout = r_to;
`else
    assign w_expire    = 1'b0;
    assign out_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT:    if (solver_done || w_expire) w_next = RESULT;
            RESULT:  if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_sums   <= '0;
            r_u      <= '0;
            r_v      <= '0;
            r_out_id <= '0;
        end else begin
            if (w_take) begin
                r_sums <= req_sums[w_gidx*SW +: SW];
                r_id   <= w_gidx;
                r_ptr  <= (w_gidx == IDW'(NUM_REQ - 1))
                          ? '0 : w_gidx + IDW'(1);
            end
            // Done outside WAIT is a stale completion and is dropped.
            if (r_state == WAIT) begin
                if (solver_done) begin
                    r_u      <= solver_u;
                    r_v      <= solver_v;
                    r_out_id <= r_id;
                end else if (w_expire) begin
                    r_u      <= '0;
                    r_v      <= '0;
                    r_out_id <= r_id;
                end
            end
        end
    end

    assign solver_start = (r_state == LAUNCH);
    assign solver_sums  = r_sums;
    assign out_valid    = (r_state == RESULT);
    assign out_u        = r_u;
    assign out_v        = r_v;
    assign out_id       = r_out_id;

endmodule

// File: tb/tb_flow_solver_sched.sv
// Self-checking bench for flow_solver_sched: directed scenarios plus
// randomized traffic against a job-level reference model.
module tb_flow_solver_sched;
    import flow_pkg::*;

    localparam int NR = 4;
    localparam int SW = 5 * ACCUM_WIDTH;
    localparam int IW = $clog2(NR);
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR*SW-1:0]     req_sums;
    logic                 solver_start;
    logic [SW-1:0]        solver_sums;
    logic                 solver_done;
    logic [15:0]          solver_u;
    logic [15:0]          solver_v;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_u;
    logic [15:0]          out_v;
    logic [IW-1:0]        out_id;
    logic                 out_timeout;
    logic                 m_done;
    logic                 inj_done;

    assign solver_done = m_done | inj_done;

    always #5 clk = ~clk;

    flow_solver_sched #(
        .NUM_REQ(NR), .ACCUM_WIDTH(ACCUM_WIDTH),
        .FLOW_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sums(req_sums),
        .solver_start(solver_start), .solver_sums(solver_sums),
        .solver_done(solver_done),
        .solver_u(solver_u), .solver_v(solver_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_u(out_u), .out_v(out_v), .out_id(out_id),
        .out_timeout(out_timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(string tag, logic [SW-1:0] got, logic [SW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- solver stand-in ----------------
    int          lat_fixed = 2;
    bit          sol_rand = 1'b1;
    logic [15:0] fu = '0;
    logic [15:0] fv = '0;
    bit          m_busy = 1'b0;

    initial begin
        int  l;
        bit  aborted;
        m_done = 1'b0;
        solver_u = '0;
        solver_v = '0;
        forever begin
            @(negedge clk);
            if (solver_start && !rst) begin
                m_busy = 1'b1;
                aborted = 1'b0;
                l = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
                for (int k = 0; k < l; k++) begin
                    @(posedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    #1;
                    m_done = 1'b1;
                    solver_u = sol_rand ? 16'($urandom) : fu;
                    solver_v = sol_rand ? 16'($urandom) : fv;
                    @(posedge clk);
                    #1;
                    m_done = 1'b0;
                end
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- job-level reference model ----------------
    bit          busy, launch_p, awaiting, have_res, exp_to;
    int          ptr, job_lane, waitcnt;
    logic [SW-1:0] job_sums;
    logic [15:0] exp_u, exp_v;
    int          n_grants, n_starts, n_xfers;
    int          g_cyc, s_cyc, v_cyc;
    logic [15:0] last_xu;
    int          last_xid;
    int          gq[$];

    function automatic int exp_grant(logic [NR-1:0] v, int p);
        for (int j = 0; j < NR; j++) begin
            if (v[(p + j) % NR]) return (p + j) % NR;
        end
        return -1;
    endfunction

    task automatic tick();
        int            g;
        logic [NR-1:0] er;
        @(negedge clk);
        cyc++;
        if (rst) begin
            busy = 0; launch_p = 0; awaiting = 0; have_res = 0; ptr = 0;
        end else begin
            g = busy ? -1 : exp_grant(req_valid, ptr);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", SW'(req_ready), SW'(er));
            chk("solver_start", SW'(solver_start), SW'(launch_p));
            chk("out_valid", SW'(out_valid), SW'(have_res));
            if (have_res) begin
                chk("out_u", SW'(out_u), SW'(exp_u));
                chk("out_v", SW'(out_v), SW'(exp_v));
                chk("out_id", SW'(out_id), SW'(job_lane));
                chk("out_timeout", SW'(out_timeout), SW'(exp_to));
            end
            if (launch_p || awaiting)
                chk("solver_sums", solver_sums, job_sums);
            if (solver_start) n_starts++;
            if (have_res) begin
                if (out_ready) begin
                    have_res = 0;
                    busy = 0;
                    n_xfers++;
                    last_xu = out_u;
                    last_xid = int'(out_id);
                end
            end else if (awaiting) begin
                if (solver_done) begin
                    exp_u = solver_u; exp_v = solver_v; exp_to = 0;
                    have_res = 1; awaiting = 0; v_cyc = cyc + 1;
                end
`ifdef FLOW_SOLVER_SCHED_TIMEOUT_EN
                else begin
                    waitcnt++;
                    if (waitcnt == TO) begin
                        exp_u = '0; exp_v = '0; exp_to = 1;
                        have_res = 1; awaiting = 0; v_cyc = cyc + 1;
                    end
                end
`endif
            end
            if (launch_p) begin
                launch_p = 0; awaiting = 1; waitcnt = 0; s_cyc = cyc;
            end
            if (g >= 0) begin
                busy = 1; launch_p = 1; job_lane = g;
                job_sums = req_sums[g*SW +: SW];
                ptr = (g + 1) % NR;
                gq.push_back(g);
                n_grants++;
                g_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_sums();
        for (int i = 0; i < NR * 5; i++)
            req_sums[i*ACCUM_WIDTH +: ACCUM_WIDTH] = $urandom;
    endtask

    task automatic wait_grant(int budget);
        int n0 = n_grants;
        int b = 0;
        while (n_grants == n0 && b < budget) begin tick(); b++; end
        chk("grant_wait", SW'(n_grants != n0), SW'(1));
    endtask

    task automatic wait_idle(int budget);
        int b = 0;
        while (busy && b < budget) begin tick(); b++; end
        chk("idle_wait", SW'(busy), SW'(0));
    endtask

    initial begin
        tensor_sums_t s;
        int b, xf0, g0, st0;
        req_valid = '0; req_sums = '0; out_ready = 1'b1; inj_done = 1'b0;
        busy = 0; launch_p = 0; awaiting = 0; have_res = 0; ptr = 0;
        n_grants = 0; n_starts = 0; n_xfers = 0;

        // reset values
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_req_ready", SW'(req_ready), SW'(0));
        chk("rst_start", SW'(solver_start), SW'(0));
        chk("rst_sums", solver_sums, SW'(0));
        chk("rst_out_valid", SW'(out_valid), SW'(0));
        chk("rst_out_u", SW'(out_u), SW'(0));
        chk("rst_out_v", SW'(out_v), SW'(0));
        chk("rst_out_id", SW'(out_id), SW'(0));
        chk("rst_out_timeout", SW'(out_timeout), SW'(0));
        tick();

        // all lanes continuously valid: round-robin order
        gq.delete();
        req_valid = '1; lat_fixed = 2; sol_rand = 1;
        b = 0;
        while (gq.size() < 5 && b < 200) begin rand_sums(); tick(); b++; end
        req_valid = '0;
        chk("rr_count", SW'(gq.size() >= 5), SW'(1));
        for (int k = 0; k < 5 && k < gq.size(); k++)
            chk("rr_order", SW'(gq[k]), SW'(k % NR));
        wait_idle(50);

        // single request on lane 2, latency 4
        s = '0;
        s.ixix = 32'sd5000; s.iyiy = 32'sd4000; s.ixit = -32'sd2500;
        req_sums = '0;
        req_sums[2*SW +: SW] = s;
        req_valid = 4'b0100; lat_fixed = 4; sol_rand = 0;
        fu = 16'h0040; fv = 16'h0000;
        wait_grant(20);
        req_valid = '0;
        wait_idle(30);
        chk("single_start_lat", SW'(s_cyc - g_cyc), SW'(1));
        chk("single_valid_lat", SW'(v_cyc - g_cyc), SW'(6));
        chk("single_u", SW'(last_xu), SW'(16'h0040));
        chk("single_id", SW'(last_xid), SW'(2));

        // backpressure, with lane 1 briefly requesting during RESULT
        rand_sums();
        req_valid = 4'b0001; lat_fixed = 3; sol_rand = 1; out_ready = 1'b0;
        wait_grant(20);
        req_valid = '0;
        b = 0;
        while (!have_res && b < 30) begin tick(); b++; end
        chk("bp_result", SW'(have_res), SW'(1));
        xf0 = n_xfers; g0 = n_grants; st0 = n_starts;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i == 2) ? 4'b0010 : 4'b0000;
            tick();
        end
        req_valid = '0;
        chk("bp_no_xfer", SW'(n_xfers), SW'(xf0));
        chk("bp_held_valid", SW'(out_valid), SW'(1));
        out_ready = 1'b1;
        tick();
        chk("bp_one_xfer", SW'(n_xfers), SW'(xf0 + 1));
        repeat (10) tick();
        chk("withdraw_no_grant", SW'(n_grants), SW'(g0));
        chk("withdraw_no_start", SW'(n_starts), SW'(st0));

        // reset during WAIT, then a stale done
        rand_sums();
        req_valid = 4'b0010; lat_fixed = 20;
        wait_grant(20);
        req_valid = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (4) tick();
        chk("rst_wait_valid", SW'(out_valid), SW'(0));
        gq.delete();
        req_valid = '1; lat_fixed = 2;
        wait_grant(20);
        req_valid = '0;
        chk("rst_ptr_zero", SW'(gq.size() > 0 ? gq[0] : -1), SW'(0));
        wait_idle(30);

        // randomized traffic
        lat_fixed = 0;
        for (int i = 0; i < 600; i++) begin
            req_valid = NR'($urandom) & NR'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_sums();
            tick();
        end
        req_valid = '0; out_ready = 1'b1;
        wait_idle(60);
        b = 0;
        while (m_busy && b < 60) begin tick(); b++; end
        chk("rand_xfers", SW'(n_xfers > 20), SW'(1));

`ifdef FLOW_SOLVER_SCHED_TIMEOUT_EN
        // watchdog: solver answers far too late
        rand_sums();
        req_valid = '1; lat_fixed = 30;
        wait_grant(20);
        req_valid = '0;
        b = 0;
        while (!have_res && b < 40) begin tick(); b++; end
        chk("to_latency", SW'(v_cyc - g_cyc), SW'(2 + TO));
        chk("to_flag", SW'(out_timeout), SW'(1));
        chk("to_u", SW'(out_u), SW'(0));
        chk("to_v", SW'(out_v), SW'(0));
        b = 0;
        while (m_busy && b < 60) begin tick(); b++; end
        repeat (3) tick();
        chk("to_late_done", SW'(out_valid), SW'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flow_solver_sched.md
Name: flow_solver_sched

Overview:
- Shares one multi-cycle flow solver core among NUM_REQ window-accumulator lanes.
- Each lane presents five structure-tensor sums (IxIx, IyIy, IxIy, IxIt, IyIt) through a valid/ready handshake.
- The block round-robin arbitrates between lanes, launches the solver with a one-cycle start pulse, waits for done, and returns flow (u, v) tagged with the lane id on a valid/ready output.
- It sits between the accumulator array and the solver core, so the divider-heavy datapath is instantiated once.

Parameters:
- NUM_REQ, 4, number of requesting accumulator lanes (2..16)
- ACCUM_WIDTH, 32, width of each signed tensor sum
- FLOW_WIDTH, 16, width of flow outputs, S8.7 fixed-point
- TIMEOUT_CYCLES, 64, watchdog limit on solver latency (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-lane request valid
- req_ready  out  NUM_REQ  per-lane accept, one-hot or zero
- req_sums  in  NUM_REQ*5*ACCUM_WIDTH  per-lane sums; lane k at slice k, field order IxIx, IyIy, IxIy, IxIt, IyIt (low to high)
- solver_start  out  1  one-cycle launch pulse
- solver_sums  out  5*ACCUM_WIDTH  operands held stable from start until done
- solver_done  in  1  solver result strobe
- solver_u  in  FLOW_WIDTH  solver u result
- solver_v  in  FLOW_WIDTH  solver v result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_u  out  FLOW_WIDTH  flow u
- out_v  out  FLOW_WIDTH  flow v
- out_id  out  $clog2(NUM_REQ)  originating lane
- out_timeout  out  1  result was forced by the watchdog

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - req_ready=0, solver_start=0, solver_sums=0
  - out_valid=0, out_u=0, out_v=0, out_id=0, out_timeout=0
  - state=IDLE, round-robin pointer=0
- State machine: IDLE -> LAUNCH -> WAIT -> RESULT -> IDLE.
- IDLE:
  - req_ready is combinational. It is one-hot on the granted lane only in IDLE when any req_valid is set.
  - Grant goes to the first valid lane at or after the pointer, wrapping modulo NUM_REQ.
  - On grant, register that lane's sums and id, set pointer=(grant+1) mod NUM_REQ, and go to LAUNCH.
- LAUNCH: solver_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On solver_done, capture solver_u, solver_v and id into the output registers, set out_valid=1, and go to RESULT.
  - solver_done arriving in the same cycle as solver_start is not possible. The solver latency is at least 1.
- RESULT:
  - Hold all outputs stable while out_valid=1 and out_ready=0.
  - On out_ready, out_valid falls on the next edge and the state returns to IDLE.
  - No request is granted in RESULT. Only one job is in flight.
- Latency: with a solver latency of L and out_ready held high:
  - grant at cycle 0, start at cycle 1, out_valid at cycle 2+L
  - next grant possible at cycle 3+L
- solver_sums stays constant from LAUNCH through WAIT.
- solver_done outside WAIT is ignored. This covers stale completions after reset.
- Reset mid-operation: all state is cleared the next edge. Any in-flight solver result is discarded.
- Requests: req_valid may drop without acceptance. A lane's sums must be stable only in its grant cycle.
- Arithmetic: none on the data. Sums and flows pass through bit-exact. The pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: FLOW_SOLVER_SCHED_TIMEOUT_EN.
- When defined:
  - A counter starts at 0 on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without solver_done, the block forces out_u=0, out_v=0, out_timeout=1, out_valid=1 and goes to RESULT.
  - A later solver_done is ignored.
- When undefined: WAIT waits indefinitely, out_timeout is tied to 0, and no counter is synthesized.

Decomposition:
- Shared package flow_pkg:
  - ACCUM_WIDTH, FLOW_WIDTH, FRAC_BITS constants
  - packed struct tensor_sums_t (five signed ACCUM_WIDTH fields, order as above)
  - enum sched_state_t {IDLE, LAUNCH, WAIT, RESULT}
- One sub-module: rr_arbiter, parameterized by N. It maps req vector and pointer to a one-hot grant plus grant index, and is purely combinational.

Test Plan:
- Single request: lane 2 valid with IxIx=5000, IyIy=4000, IxIy=0, IxIt=-2500, IyIt=0; solver model L=4 returns u=0x0040 -> req_ready[2] at cycle 0, solver_start at cycle 1, out_valid at cycle 6 with out_u=0x0040, out_id=2.
- All four lanes valid continuously, out_ready=1 -> grants in order 0,1,2,3,0. Each lane's sums appear on solver_sums unchanged.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, no req_ready pulses, a single transfer when out_ready rises.
- Reset asserted during WAIT, then solver_done pulsed 2 cycles after reset release -> out_valid stays 0, state IDLE, pointer=0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): solver never asserts done -> out_valid at 8 WAIT cycles with out_u=0, out_v=0, out_timeout=1. A late done is ignored.
- Request withdrawn: lane 1 valid for one cycle while the block is in RESULT, then dropped -> lane 1 never granted, no solver_start issued.
